// File: rtl/cam_lookup_insert_ctrl_pkg.sv
// Shared types and constants for the CAM lookup/insert control slice.
//   cam_op_t      : request opcode (LOOKUP = 0, INSERT = 1)
//   cam_idx_t     : 3-bit CAM entry index
//   cam_key_t     : 8-bit CAM key
//   cam_state_t   : control FSM state (IDLE, SEARCH, WRITE, RESP)
//   CAM_NUM_ENTRIES : number of CAM entries (8)
package cam_ctrl_pkg;

    localparam int unsigned CAM_NUM_ENTRIES = 8;

    typedef enum logic {
        LOOKUP = 1'b0,
        INSERT = 1'b1
    } cam_op_t;

    typedef logic [2:0] cam_idx_t;
    typedef logic [7:0] cam_key_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        WRITE,
        RESP
    } cam_state_t;

endpackage

// File: rtl/cam_lookup_insert_ctrl_if.sv
// Bundle of the request, response and CAM-side signals of
// cam_lookup_insert_ctrl.
//   slave  : the controller side (consumes requests, drives CAM ports)
//   master : the environment side (issues requests, models the CAM)
// When CAM_LOOKUP_INSERT_CTRL_FLUSH_EN is defined a 1-bit flush input to
// the controller is added.
interface cam_lookup_insert_ctrl_if;
    import cam_ctrl_pkg::*;

    logic     req_val;
    logic     req_rdy;
    logic     req_op;
    cam_key_t req_data;

    logic     resp_val;
    logic     resp_rdy;
    logic     resp_hit;
    cam_idx_t resp_idx;

    logic     cam_write_en;
    cam_idx_t cam_write_addr;
    cam_key_t cam_write_data;
    logic     cam_search_en;
    cam_key_t cam_search_data;
    logic [CAM_NUM_ENTRIES-1:0] cam_search_match;

`ifdef CAM_LOOKUP_INSERT_CTRL_FLUSH_EN
    logic     flush;

    modport slave (
        input  req_val, req_op, req_data, resp_rdy, cam_search_match, flush,
        output req_rdy, resp_val, resp_hit, resp_idx,
               cam_write_en, cam_write_addr, cam_write_data,
               cam_search_en, cam_search_data
    );

    modport master (
        output req_val, req_op, req_data, resp_rdy, cam_search_match, flush,
        input  req_rdy, resp_val, resp_hit, resp_idx,
               cam_write_en, cam_write_addr, cam_write_data,
               cam_search_en, cam_search_data
    );
`else
    modport slave (
        input  req_val, req_op, req_data, resp_rdy, cam_search_match,
        output req_rdy, resp_val, resp_hit, resp_idx,
               cam_write_en, cam_write_addr, cam_write_data,
               cam_search_en, cam_search_data
    );

    modport master (
        output req_val, req_op, req_data, resp_rdy, cam_search_match,
        input  req_rdy, resp_val, resp_hit, resp_idx,
               cam_write_en, cam_write_addr, cam_write_data,
               cam_search_en, cam_search_data
    );
`endif

endinterface

// File: rtl/cam_lookup_insert_ctrl_prio_enc8.sv
// cam_prio_enc8: 8-bit lowest-set-bit priority encoder.
//   vec : input bit vector
//   idx : index of the lowest set bit of vec (0 when vec is zero)
//   any : 1 when any bit of vec is set
module cam_prio_enc8
    import cam_ctrl_pkg::*;
(
    input  logic [7:0] vec,
    output cam_idx_t   idx,
    output logic       any
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (vec[i] && !found) begin
                idx   = cam_idx_t'(i);
                found = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/cam_lookup_insert_ctrl.sv
// cam_lookup_insert_ctrl: control stage in front of an 8 x 8-bit CAM.
// Accepts lookup/insert requests, drives the CAM search/write ports, masks
// the CAM match vector with per-entry valid bits, allocates entries (lowest
// free first, round-robin victim when full) and returns hit/index.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   bus    : cam_lookup_insert_ctrl_if.slave
//            req_val/req_rdy/req_op/req_data   request channel
//            resp_val/resp_rdy/resp_hit/resp_idx response channel
//            cam_write_en/addr/data, cam_search_en/data, cam_search_match
// Optional: define CAM_LOOKUP_INSERT_CTRL_FLUSH_EN to add bus.flush, which
// empties the table when sampled in IDLE (priority over req_val).
module cam_lookup_insert_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int unsigned p_num_entries = 8,
    parameter int unsigned p_data_nbits  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    cam_lookup_insert_ctrl_if.slave  bus
);

    cam_state_t                state_q;
    cam_state_t                state_d;
    cam_op_t                   op_r;
    logic [p_data_nbits-1:0]   key_r;
    logic [p_num_entries-1:0]  valid;
    cam_idx_t                  victim;
    cam_idx_t                  alloc_r;
    logic                      alloc_victim_r;
    logic                      hit_r;
    cam_idx_t                  idx_r;

    logic [7:0]                match_masked;
    cam_idx_t                  match_idx;
    logic                      match_any;
    cam_idx_t                  free_idx;
    logic                      free_any;
    cam_idx_t                  alloc;
    logic                      flush_req;

`ifdef CAM_LOOKUP_INSERT_CTRL_FLUSH_EN
    assign flush_req = bus.flush;
`else
    assign flush_req = 1'b0;
`endif

    // Stale CAM contents never hit: matches only count on valid entries.
    assign match_masked = bus.cam_search_match & valid;

    cam_prio_enc8 u_match_enc (
        .vec (match_masked),
        .idx (match_idx),
        .any (match_any)
    );

    cam_prio_enc8 u_free_enc (
        .vec (~valid),
        .idx (free_idx),
        .any (free_any)
    );

    assign alloc = free_any ? free_idx : victim;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flush_req && bus.req_val) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (op_r == INSERT && !match_any) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_rdy         = (state_q == IDLE) && !flush_req;
        bus.resp_val        = (state_q == RESP);
        bus.resp_hit        = hit_r;
        bus.resp_idx        = idx_r;
        bus.cam_search_en   = (state_q == SEARCH);
        bus.cam_search_data = key_r;
        bus.cam_write_en    = (state_q == WRITE);
        bus.cam_write_addr  = alloc_r;
        bus.cam_write_data  = key_r;
    end

    // Request, table and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r           <= LOOKUP;
            key_r          <= '0;
            valid          <= '0;
            victim         <= '0;
            alloc_r        <= '0;
            alloc_victim_r <= 1'b0;
            hit_r          <= 1'b0;
            idx_r          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        valid  <= '0;
                        victim <= '0;
                    end else if (bus.req_val) begin
                        op_r  <= cam_op_t'(bus.req_op);
                        key_r <= bus.req_data;
                    end
                end
                SEARCH: begin
                    if (op_r == LOOKUP || match_any) begin
                        hit_r <= match_any;
                        idx_r <= match_idx;
                    end else begin
                        alloc_r        <= alloc;
                        alloc_victim_r <= !free_any;
                    end
                end
                WRITE: begin
                    valid[alloc_r] <= 1'b1;
                    if (alloc_victim_r) begin
                        victim <= victim + 3'd1;
                    end
                    hit_r <= 1'b0;
                    idx_r <= alloc_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_lookup_insert_ctrl.sv
// Self-checking bench for cam_lookup_insert_ctrl. Models the CAM array
// (with garbage initial contents) and keeps a table-level reference model
// of keys, valid bits and victim pointer. Directed scenarios followed by
// randomized lookup/insert traffic with random response back-pressure.
// Flush scenario runs when CAM_LOOKUP_INSERT_CTRL_FLUSH_EN is defined.
module tb_cam_lookup_insert_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cam_lookup_insert_ctrl_if bus();

    cam_lookup_insert_ctrl #(
        .p_num_entries (8),
        .p_data_nbits  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // CAM array model: write on clock, combinational search.
    logic [7:0] cam_mem [8];

    always @(posedge clk) begin
        if (bus.cam_write_en) cam_mem[bus.cam_write_addr] <= bus.cam_write_data;
    end

    always_comb begin
        bus.cam_search_match = '0;
        for (int i = 0; i < 8; i++) begin
            if (cam_mem[i] == bus.cam_search_data) bus.cam_search_match[i] = 1'b1;
        end
    end

    // Reference model of the logical table.
    bit         ref_valid [8];
    logic [7:0] ref_key   [8];
    int         ref_victim;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        ref_victim = 0;
    endfunction

    function automatic void model_op(input bit op, input logic [7:0] k,
                                     output bit hit, output int idx, output bit wr);
        int free_i;
        hit = 1'b0; idx = 0; wr = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (ref_valid[i] && ref_key[i] == k) begin hit = 1'b1; idx = i; end
        end
        if (op && !hit) begin
            free_i = -1;
            for (int i = 7; i >= 0; i--) if (!ref_valid[i]) free_i = i;
            if (free_i >= 0) idx = free_i;
            else begin
                idx = ref_victim;
                ref_victim = (ref_victim + 1) % 8;
            end
            ref_valid[idx] = 1'b1;
            ref_key[idx]   = k;
            wr = 1'b1;
        end
    endfunction

    // Issue one request and check the full transaction. Entered and left
    // 1 time unit after a rising edge.
    task automatic do_req(input bit op, input logic [7:0] k, input int stall);
        bit eh, ew, wseen, got;
        int ei, cyc;
        model_op(op, k, eh, ei, ew);
        bus.resp_rdy = (stall == 0);
        bus.req_val  = 1'b1;
        bus.req_op   = op;
        bus.req_data = k;
        cyc = 0;
        while (!bus.req_rdy && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (!bus.req_rdy) check("req_rdy_timeout", bus.req_rdy, 1);
        @(posedge clk); #1;
        bus.req_val = 1'b0;
        cyc = 1; wseen = 1'b0; got = 1'b0;
        while (cyc <= 10 && !got) begin
            if (bus.cam_search_en) check("search_data", bus.cam_search_data, k);
            if (bus.cam_write_en) begin
                wseen = 1'b1;
                check("write_addr", bus.cam_write_addr, ei);
                check("write_data", bus.cam_write_data, k);
            end
            if (bus.resp_val) got = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check("resp_timeout", got, 1);
        if (got) begin
            check("latency", cyc, ew ? 3 : 2);
            check("resp_hit", bus.resp_hit, eh);
            check("resp_idx", bus.resp_idx, ei);
            check("write_strobe", wseen, ew);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                check("stall_val", bus.resp_val, 1);
                check("stall_hit", bus.resp_hit, eh);
                check("stall_idx", bus.resp_idx, ei);
                check("stall_req_rdy", bus.req_rdy, 0);
            end
            bus.resp_rdy = 1'b1;
            @(posedge clk); #1;
            check("resp_drop", bus.resp_val, 0);
            check("idle_req_rdy", bus.req_rdy, 1);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        bus.req_val  = 1'b0;
        bus.resp_rdy = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        reset        = 1'b1;
        bus.req_val  = 1'b0;
        bus.req_op   = 1'b0;
        bus.req_data = '0;
        bus.resp_rdy = 1'b1;
`ifdef CAM_LOOKUP_INSERT_CTRL_FLUSH_EN
        bus.flush    = 1'b0;
`endif
        // Garbage CAM contents, including keys used later, to expose
        // any match that is not masked by the valid bits.
        for (int i = 0; i < 8; i++) cam_mem[i] = 8'($urandom);
        cam_mem[3] = 8'h3C;
        cam_mem[6] = 8'h55;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_val", bus.resp_val, 0);
        check("rst_resp_hit", bus.resp_hit, 0);
        check("rst_resp_idx", bus.resp_idx, 0);
        check("rst_write_en", bus.cam_write_en, 0);
        check("rst_search_en", bus.cam_search_en, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_req_rdy0", bus.req_rdy, 1);

        // Lookup into empty table.
        do_req(1'b0, 8'h3C, 0);
        // Inserts into empty table, lookup, duplicate insert.
        do_req(1'b1, 8'hA1, 0);
        do_req(1'b1, 8'hB2, 0);
        do_req(1'b1, 8'hC3, 0);
        do_req(1'b0, 8'hB2, 0);
        do_req(1'b1, 8'hB2, 0);

        // Fill and wrap the victim pointer.
        reset_dut();
        for (int i = 0; i < 8; i++) do_req(1'b1, 8'(8'h10 + i), 0);
        do_req(1'b1, 8'h20, 0);
        do_req(1'b1, 8'h21, 0);
        do_req(1'b0, 8'h10, 0);
        do_req(1'b0, 8'h21, 0);

        // Response stall, then back-to-back request.
        do_req(1'b0, 8'h21, 5);
        do_req(1'b0, 8'h12, 0);

        // Reset during WRITE of an insert aborts it.
        bus.req_val  = 1'b1;
        bus.req_op   = 1'b1;
        bus.req_data = 8'h55;
        bus.resp_rdy = 1'b1;
        @(posedge clk); #1;
        bus.req_val = 1'b0;
        @(posedge clk); #1;
        check("abort_in_write", bus.cam_write_en, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_no_resp0", bus.resp_val, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_resp", bus.resp_val, 0);
        end
        do_req(1'b0, 8'h55, 0);
        do_req(1'b1, 8'h66, 0);

`ifdef CAM_LOOKUP_INSERT_CTRL_FLUSH_EN
        do_req(1'b1, 8'h77, 0);
        bus.flush   = 1'b1;
        bus.req_val = 1'b1;
        bus.req_op  = 1'b0;
        #1;
        check("flush_req_rdy", bus.req_rdy, 0);
        @(posedge clk); #1;
        bus.flush   = 1'b0;
        bus.req_val = 1'b0;
        check("flush_no_accept", bus.cam_search_en, 0);
        model_clear();
        do_req(1'b0, 8'h66, 0);
        do_req(1'b0, 8'h77, 0);
        do_req(1'b1, 8'h88, 0);
`endif

        // Randomized traffic over a key pool larger than the table.
        reset_dut();
        repeat (200) begin
            do_req(1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 11)),
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cam_lookup_insert_ctrl.md
Name: cam_lookup_insert_ctrl

Overview:
- Control stage directly upstream of the 8-entry x 8-bit single-search/single-write CAM.
- Accepts lookup/insert requests on a val/rdy interface and drives the CAM write and search ports.
- Consumes the CAM's combinational search_match vector, applies per-entry valid bits and priority encoding, and returns hit/index on a val/rdy response interface.
- Owns entry allocation: lowest free entry first, round-robin victim when all entries are valid.

Parameters:
- p_num_entries, 8, number of CAM entries; only 8 supported (index width 3).
- p_data_nbits, 8, key width; only 8 supported.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_val  input  1  request valid
- req_rdy  output  1  request ready
- req_op  input  1  0 = lookup, 1 = insert
- req_data  input  8  key
- resp_val  output  1  response valid
- resp_rdy  input  1  response ready
- resp_hit  output  1  key present (lookup), or already present (insert)
- resp_idx  output  3  matching or allocated entry index; 0 when lookup misses
- cam_write_en  output  1  to CAM write_en
- cam_write_addr  output  3  to CAM write_addr
- cam_write_data  output  8  to CAM write_data
- cam_search_en  output  1  to CAM search_en
- cam_search_data  output  8  to CAM search_data
- cam_search_match  input  8  from CAM search_match

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- On reset:
  - state = IDLE; valid[7:0] = 0; victim = 0.
  - resp_val = 0, resp_hit = 0, resp_idx = 0.
  - cam_write_en = 0, cam_search_en = 0.
- Request is held in registers op_r and key_r.
- FSM states:
  - IDLE:
    - req_rdy = 1; all other strobes 0.
    - On req_val, latch op/key and go to SEARCH.
  - SEARCH:
    - cam_search_en = 1, cam_search_data = key_r.
    - Compute m = cam_search_match & valid. hit = |m. idx = lowest set bit of m.
    - Lookup: register hit/idx and go to RESP.
    - Insert with hit: register hit = 1, idx, and go to RESP.
    - Insert with miss: register alloc index and go to WRITE.
  - WRITE:
    - cam_write_en = 1, cam_write_addr = alloc, cam_write_data = key_r.
    - Set valid[alloc].
    - If alloc came from the victim pointer, victim <= victim + 1 (wraps 7 -> 0).
    - Register hit = 0, idx = alloc; go to RESP.
  - RESP:
    - resp_val = 1; resp_hit/resp_idx held stable.
    - On resp_rdy, go to IDLE.
- Allocation rule:
  - If any valid bit is clear, alloc = lowest index with valid = 0.
  - If all 8 entries are valid, alloc = victim.
- req_rdy is 1 only in IDLE, so at most one request is in flight; there is no pipelining.
- Latency (request accepted in cycle 0):
  - Lookup and insert-hit: resp_val in cycle 2.
  - Insert-miss: resp_val in cycle 3.
- A resp_rdy stall in RESP holds the state indefinitely; no new request is accepted.
- The CAM write in WRITE is visible to the CAM search from the next cycle onward.
- Uninitialised CAM contents never produce a hit, because matches are masked by valid.
- Duplicate matches (after overwrite) resolve to the lowest index.
- cam_*_data outputs are don't-care when their enable is 0; the bench checks them only when enabled.
- Reset in any state aborts the operation:
  - No response is produced.
  - All valid bits are cleared (the table is logically empty).

Optional Feature:
- Macro: CAM_LOOKUP_INSERT_CTRL_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush sampled in IDLE: clears valid[7:0] and victim to 0 on that edge.
  - req_rdy = 0 in that cycle; flush has priority over req_val.
  - flush is ignored outside IDLE.
- Undefined: no flush port; the table is emptied only by reset.

Decomposition:
- Shared package cam_ctrl_pkg:
  - typedef cam_op_t (LOOKUP = 0, INSERT = 1).
  - typedef cam_idx_t [2:0], cam_key_t [7:0].
  - FSM state enum (IDLE, SEARCH, WRITE, RESP).
  - Constant CAM_NUM_ENTRIES = 8.
- One natural sub-module: cam_prio_enc8. It is an 8-bit lowest-set-bit encoder producing idx and any, and is reused for match select and free-entry select (applied to ~valid).

Test Plan:
- Reset, then lookup 0x3C -> resp_val in cycle 2, hit = 0, idx = 0; cam_write_en never asserted.
- Insert 0xA1, 0xB2, 0xC3 into an empty table -> responses hit = 0 with idx = 0, 1, 2. Then lookup 0xB2 -> hit = 1, idx = 1.
- Insert 0xB2 again -> hit = 1, idx = 1. No WRITE cycle; cam_write_en stays 0; response in cycle 2.
- Fill table with 0x10..0x17 (idx 0..7), then insert 0x20 -> idx = 0 (victim). Insert 0x21 -> idx = 1. Lookup 0x10 -> hit = 0; lookup 0x21 -> hit = 1, idx = 1.
- Hold resp_rdy = 0 for 5 cycles after lookup -> resp_val, hit and idx stable; req_rdy = 0 throughout. Release -> IDLE next cycle; back-to-back request accepted.
- Reset asserted during WRITE of insert 0x55 -> no response. Subsequent lookup 0x55 -> hit = 0. With flush enabled: flush after inserts -> lookups miss and the next insert gets idx = 0.
